// File: rtl/hdlc_rx_pkg.sv
// Shared types and constants for the HDLC receive bit-level front end.
// No logic or latency of its own; no backpressure.
// The optional abort comparator is controlled by HDLC_RX_ABORT_DETECT_EN.
package hdlc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLAG_SEEN = 2'd1,
        IN_FRAME  = 2'd2
    } rx_state_t;

    localparam logic [7:0] HDLC_FLAG  = 8'h7E;
    localparam logic [6:0] HDLC_ABORT = 7'h7F;
    localparam logic [2:0] STUFF_ONES = 3'd5;

    // Run-length of ones saturates so long runs (abort disabled) never wrap back to 5.
    function automatic logic [2:0] onesInc(input logic [2:0] cnt);
        return (cnt == 3'd7) ? cnt : cnt + 3'd1;
    endfunction

    function automatic logic [7:0] byteInc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/hdlc_rx_pattern_detect.sv
// Eight-bit delay line with data-eligibility mask and flag/abort compares (abort only with HDLC_RX_ABORT_DETECT_EN).
// Hits are combinational on the incoming bit; the exit bit is the one leaving the line this cycle.
// No backpressure: advances only on en, otherwise holds.
module hdlc_rx_pattern_detect
    import hdlc_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rxBit,
    input  logic hunting,
    output logic flagHit,
    output logic abortHit,
    output logic exitBit,
    output logic exitValid
);

    logic [7:0] sr;
    logic [7:0] vm;
    logic [7:0] srNext;

    assign srNext = {rxBit, sr[7:1]};
    assign flagHit = en && (srNext == HDLC_FLAG);

`ifdef HDLC_RX_ABORT_DETECT_EN
    assign abortHit = en && (srNext[7:1] == HDLC_ABORT);
`else
    assign abortHit = 1'b0;
`endif

    assign exitBit   = sr[0];
    assign exitValid = en && vm[0];

    // A flag wipes the mask so none of its own bits ever leave as data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= 8'h00;
            vm <= 8'h00;
        end else if (en) begin
            sr <= srNext;
            vm <= flagHit ? 8'h00 : {~hunting, vm[7:1]};
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC Rx deframer: flag hunt, abort detect (HDLC_RX_ABORT_DETECT_EN), zero de-stuffing, LSB-first byte assembly.
// Strobes registered one cycle after the causing edge; a data byte appears 8 enabled cycles after its last bit.
// No backpressure: consumer must accept every strobe; RxEN=0 freezes all state.
module hdlc_rx_deframer
    import hdlc_rx_pkg::*;
#(
    parameter int MIN_BYTES = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_ValidFrame,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_EoF,
    output logic       Rx_FrameError,
    output logic       ZeroDetect
);

    localparam logic [7:0] MinBytes = 8'(MIN_BYTES);

    rx_state_t  state, stateNext;
    logic [2:0] bitCnt, bitCntNext;
    logic [7:0] byteCnt, byteCntNext;
    logic [2:0] onesCnt, onesNext;
    logic [7:0] asmReg, asmNext;
    logic [7:0] dataNext;
    logic       newByteNext, eofNext, errNext, abortNext, zeroNext;

    logic flagHit, abortHit, exitBit, exitValid;

    hdlc_rx_pattern_detect uPattern (
        .clk       (Clk),
        .rst       (Rst),
        .en        (RxEN),
        .rxBit     (Rx),
        .hunting   (state == IDLE),
        .flagHit   (flagHit),
        .abortHit  (abortHit),
        .exitBit   (exitBit),
        .exitValid (exitValid)
    );

    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        byteCntNext = byteCnt;
        onesNext    = onesCnt;
        asmNext     = asmReg;
        dataNext    = Rx_Data;
        newByteNext = 1'b0;
        eofNext     = 1'b0;
        errNext     = 1'b0;
        abortNext   = 1'b0;
        zeroNext    = 1'b0;

        // The exit bit is handled first so a byte finishing on the closing
        // flag edge is counted before the frame is judged.
        if (state != IDLE) begin
            if (exitValid) begin
                if (!exitBit && (onesCnt == STUFF_ONES)) begin
                    zeroNext = 1'b1;
                    onesNext = 3'd0;
                end else begin
                    onesNext   = exitBit ? onesInc(onesCnt) : 3'd0;
                    asmNext    = {exitBit, asmReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (state == FLAG_SEEN) begin
                        stateNext = IN_FRAME;
                    end
                    if (bitCnt == 3'd7) begin
                        newByteNext = 1'b1;
                        dataNext    = asmNext;
                        byteCntNext = byteInc(byteCnt);
                    end
                end
            end else if (RxEN) begin
                onesNext = 3'd0;
            end
        end

        if (flagHit) begin
            if (stateNext == IN_FRAME) begin
                eofNext = 1'b1;
                errNext = (bitCntNext != 3'd0) || (byteCntNext < MinBytes);
            end
            stateNext   = FLAG_SEEN;
            bitCntNext  = 3'd0;
            byteCntNext = 8'd0;
            onesNext    = 3'd0;
        end else if (abortHit && (state != IDLE)) begin
            abortNext   = 1'b1;
            stateNext   = IDLE;
            bitCntNext  = 3'd0;
            byteCntNext = 8'd0;
            onesNext    = 3'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            bitCnt         <= 3'd0;
            byteCnt        <= 8'd0;
            onesCnt        <= 3'd0;
            asmReg         <= 8'h00;
            Rx_Data        <= 8'h00;
            Rx_NewByte     <= 1'b0;
            Rx_ValidFrame  <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;
            ZeroDetect     <= 1'b0;
        end else begin
            if (RxEN) begin
                state         <= stateNext;
                bitCnt        <= bitCntNext;
                byteCnt       <= byteCntNext;
                onesCnt       <= onesNext;
                asmReg        <= asmNext;
                Rx_Data       <= dataNext;
                Rx_ValidFrame <= (stateNext == IN_FRAME);
            end
            Rx_NewByte     <= RxEN && newByteNext;
            Rx_FlagDetect  <= RxEN && flagHit;
            Rx_AbortDetect <= RxEN && abortNext;
            Rx_EoF         <= RxEN && eofNext;
            Rx_FrameError  <= RxEN && errNext;
            ZeroDetect     <= RxEN && zeroNext;
        end
    end

endmodule
